// File: rtl/delay_line_if.sv
// Bus bundle for the programmable delay line: control, input sample and
// delayed output. clk and resetn stay plain ports on the module.
interface delay_line_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] delay;
  logic [WIDTH-1:0]      din;
  logic [WIDTH-1:0]      dout;
  logic                  dout_valid;

  modport master (
    output en,
    output delay,
    output din,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  en,
    input  delay,
    input  din,
    output dout,
    output dout_valid
  );
endinterface

// File: rtl/delay_line.sv
// Runtime-programmable delay line: circular buffer with a free-running write
// pointer, a read address trailing it by D-1, a fill counter gating
// dout_valid, and a registered output. A change of the effective delay
// (including the first edge after reset) flushes the line.
module delay_line #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
) (
  input logic        clk,
  input logic        resetn,
  delay_line_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] delay_q;
  logic [WIDTH-1:0]      dout_q;
  logic                  valid_q;

  logic [ADDR_WIDTH-1:0] delay_eff;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] fill_next;
  logic                  load;
  logic                  advance;
  logic                  valid_next;
  logic [WIDTH-1:0]      tap;

  // Effective delay, load detection and next-state of the fill tracking.
  // delay_q resets to 0 and the effective delay is never 0, so the first
  // edge after reset is always a load.
  always_comb begin
    delay_eff  = (bus.delay == '0) ? ONE : bus.delay;
    load       = (delay_eff != delay_q);
    advance    = bus.en && !load;
    rd_addr    = wr_ptr - delay_q + ONE;
    fill_next  = (fill == delay_q) ? fill : fill + ONE;
    valid_next = valid_q || (fill_next == delay_q);
    // At D=1 the read address equals the write address; take the incoming
    // sample directly instead of the stale buffer word.
    tap        = (delay_q == ONE) ? bus.din : mem[rd_addr];
  end

  // Sample buffer write; contents need no reset since dout_valid gates them.
  always_ff @(posedge clk) begin
    if (advance) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  // Pointer, fill counter, applied delay and registered output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      fill    <= '0;
      delay_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      delay_q <= delay_eff;
      fill    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.en) begin
      wr_ptr  <= wr_ptr + ONE;
      fill    <= fill_next;
      valid_q <= valid_next;
      dout_q  <= valid_next ? tap : '0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;

endmodule

// File: doc/delay_line.md
Name: delay_line

Overview:
- Parametrised, runtime-programmable delay line. Generalises the single-bit one-cycle register delay to a WIDTH-bit bus with a programmable delay of 1..2^ADDR_WIDTH-1 cycles.
- Clock-enable gating and an output-valid flag that tracks pipeline fill after reset or after a delay change.
- Used in the FPGA datapath to align ADC/DAC or trigger streams with processing latency.
- Built as a circular buffer with write and read pointers, a fill counter, and a registered output.

Parameters:
- WIDTH, 16, data bus width in bits.
- ADDR_WIDTH, 10, buffer address width. Maximum delay is 2^ADDR_WIDTH-1 cycles.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  clock enable. Only edges with en=1 ("enabled edges") advance the line.
- delay  in  ADDR_WIDTH  requested delay D. Quasi-static. The value 0 is treated as 1.
- din  in  WIDTH  input sample.
- dout  out  WIDTH  delayed sample. Forced to 0 while dout_valid=0.
- dout_valid  out  1  high once the line holds D samples taken since the last load.

Behaviour:
- Effective delay: De = (delay==0) ? 1 : delay.
- Internal register delay_q holds the applied delay. It resets to 0.
- Load event: any rising edge where De != delay_q, regardless of en.
  - The first edge after resetn release is always a load event, because De is never 0.
  - On a load event: delay_q <= De, fill counter <= 0, dout <= 0, dout_valid <= 0.
  - On a load edge, din is not counted. It may be written to the buffer but must never appear on dout.
- Enabled edge, not a load event:
  - din is written at the write pointer; the write pointer increments modulo 2^ADDR_WIDTH.
  - The fill counter increments, saturating at delay_q.
  - dout is registered.
- Latency: din sampled at enabled edge k appears on dout immediately after enabled edge k+D-1.
  - D=1 is identical to a plain register: dout <= din.
  - Latency counts enabled edges only.
- dout_valid is set on the enabled edge at which the fill counter reaches delay_q.
  - After a load, the first valid output follows the D-th counted enabled edge and equals the 1st counted sample.
  - While dout_valid=0, dout is 0.
- en=0 and no load event: buffer, pointers, fill counter, dout and dout_valid all hold.
- A load event during en=0 still clears dout and dout_valid.
- Pointer wrap: the write pointer wraps modulo 2^ADDR_WIDTH. The read address is (write pointer - D + 1) mod 2^ADDR_WIDTH, which is correct across the wrap.
  - The read-during-write case at D=1 must return the new din, implemented as a bypass.
  - D = 2^ADDR_WIDTH-1 is the maximum; no sample is overwritten before it is read.
- Delay change mid-stream: the line flushes as defined above. No stale sample from before the load may appear with dout_valid=1.
- Asynchronous reset (resetn=0): dout=0, dout_valid=0, pointers=0, fill counter=0, delay_q=0, effective immediately. Buffer contents are unspecified.
  - Reset asserted mid-stream aborts everything.
  - After release, the first edge is a load edge.
- Buffer implementation: inferred block RAM with a registered read.
  - Fill counter width: ADDR_WIDTH.
  - No combinational path from din to dout.

Test Plan:
All scenarios use WIDTH=16, ADDR_WIDTH=4.
- Reset/D=1: release resetn, delay=1, en=1, din=counter (0,1,2…) sampled per edge.
  - Edge 1 is a load (sample 0 dropped), dout=0, dout_valid=0.
  - After edge 2: dout=1, dout_valid=1.
  - Thereafter dout equals the din from the same edge.
- D=5 steady state: delay=5, din=0x1000+n at edge n.
  - Load at edge 1. dout_valid rises after edge 6 with dout=0x1002 (sample of edge 2).
  - After edge 7, dout=0x1003.
  - dout stays 0 before edge 6.
- Max delay and wrap: delay=15, ramp input for 40 edges.
  - dout_valid first goes high after edge 16, then dout(edge k)=din(edge k-14) continuously across pointer wrap.
  - No glitch.
- Clock enable: D=3, valid stream, toggle en=0 for 4 cycles mid-stream.
  - dout and dout_valid hold during the gap.
  - On resumption, the sequence continues with no skipped or duplicated samples. Latency is counted in enabled edges.
- Delay change: steady D=4, switch delay to 2 at edge m.
  - After edge m: dout=0, dout_valid=0.
  - After edge m+2: dout_valid=1, dout=din(m+1).
  - No pre-change value appears while valid.
- delay=0 and async reset: delay=0 behaves as D=1.
  - Assert resetn=0 mid-cycle: dout=0 and dout_valid=0 immediately, without waiting for a clock edge.
  - On release, recovery follows the reset scenario.
